// File: rtl/param_fifo_if.sv
// Handshake and status bundle between a FIFO producer/consumer and param_fifo.
interface param_fifo_if #(
    parameter int unsigned WIDTH = 15,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic             clear_err;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_en, wr_data, rd_en, clear_err,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, clear_err,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/param_fifo.sv
// Synchronous FIFO with registered read data, threshold flags and sticky errors.
module param_fifo #(
    parameter int unsigned WIDTH    = 15,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic          clk,
    input  logic          rst,
    param_fifo_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]    wr_ptr_q,    wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q,    rd_ptr_d;
    logic [CW-1:0]    count_q,     count_d;
    logic [WIDTH-1:0] rd_data_q,   rd_data_d;
    logic             rd_valid_q,  rd_valid_d;
    logic             full_q,      full_d;
    logic             empty_q,     empty_d;
    logic             af_q,        af_d;
    logic             ae_q,        ae_d;
    logic             overflow_q,  overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_acc_c;
    logic             rd_acc_c;

    // Accept decisions: a full FIFO still takes a write when a read frees a slot.
    always_comb begin
        rd_acc_c = bus.rd_en && !empty_q;
        wr_acc_c = bus.wr_en && (!full_q || rd_acc_c);
    end

    // Next-state for pointers, occupancy, flags, read data and sticky errors.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q && !bus.clear_err;
        underflow_d = underflow_q && !bus.clear_err;

        if (wr_acc_c) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_acc_c) begin
            rd_ptr_d   = rd_ptr_q + PW'(1);
            rd_data_d  = mem_q[rd_ptr_q[AW-1:0]];
            rd_valid_d = 1'b1;
        end
        if (wr_acc_c && !rd_acc_c) begin
            count_d = count_q + CW'(1);
        end else if (rd_acc_c && !wr_acc_c) begin
            count_d = count_q - CW'(1);
        end

        if (bus.wr_en && !wr_acc_c) begin
            overflow_d = 1'b1;
        end
        if (bus.rd_en && empty_q) begin
            underflow_d = 1'b1;
        end

        full_d  = (count_d == FULL_C);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            af_q        <= af_d;
            ae_q        <= ae_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents survive reset since pointers make them unreachable.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc_c) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.wr_data;
        end
    end

    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter: WIDTH, 15, data word width in bits (≥1).
REQ-002 Parameter: DEPTH, 8, number of storage entries; a power of two, ≥2.
REQ-003 Parameter: AF_LEVEL, DEPTH-2, occupancy at or above which almost_full asserts (1..DEPTH).
REQ-004 Parameter: AE_LEVEL, 2, occupancy at or below which almost_empty asserts (0..DEPTH-1).
REQ-005 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 Port: rst  input  1  synchronous, active-high reset.
REQ-007 Port: wr_en  input  1  write request.
REQ-008 Port: wr_data  input  WIDTH  write data.
REQ-009 Port: rd_en  input  1  read request.
REQ-010 Port: rd_data  output  WIDTH  registered read data.
REQ-011 Port: rd_valid  output  1  rd_data updated this cycle by an accepted read.
REQ-012 Port: full, empty  output  1 each  occupancy == DEPTH, occupancy == 0.
REQ-013 Port: almost_full, almost_empty  output  1 each  threshold flags.
REQ-014 Port: count  output  $clog2(DEPTH+1)  current occupancy.
REQ-015 Port: overflow, underflow  output  1 each  sticky error flags.
REQ-016 Port: clear_err  input  1  synchronous clear of the sticky error flags.

Function
REQ-017 Storage SHALL be a DEPTH x WIDTH array indexed by write and read pointers of $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty, and the low bits wrap from DEPTH-1 to 0.
REQ-018 A write SHALL be accepted when wr_en=1 and either full=0, or full=1 and a read is accepted in the same cycle.
REQ-019 A read SHALL be accepted when rd_en=1 and empty=0; a write in the same cycle SHALL NOT bypass to the output when empty=1.
REQ-020 On an accepted write, wr_data SHALL be stored at the write pointer, and the pointer SHALL increment by 1.
REQ-021 On an accepted read, rd_data SHALL load mem[read pointer] at that edge (1-cycle latency), rd_valid SHALL be 1 for that cycle, and the read pointer SHALL increment by 1.
REQ-022 When no read is accepted, rd_data SHALL hold its previous value and rd_valid SHALL be 0.
REQ-023 count SHALL update as follows: +1 on a write only, -1 on a read only, unchanged on both or neither.
REQ-024 full, empty, almost_full (count ≥ AF_LEVEL) and almost_empty (count ≤ AE_LEVEL) SHALL be registered and consistent with count in the same cycle.
REQ-025 wr_en=1 with the write rejected SHALL set overflow; data and pointers SHALL be unchanged.
REQ-026 rd_en=1 with empty=1 SHALL set underflow; rd_data and pointers SHALL be unchanged.
REQ-027 overflow and underflow SHALL remain set until clear_err=1 or rst=1; if a new error and clear_err coincide, the flag SHALL be set.
REQ-028 Simultaneous read and write at count=DEPTH SHALL leave count=DEPTH, and the read SHALL return the oldest entry.

Reset
REQ-029 On rst=1 at a clock edge, both pointers and count SHALL go to 0, with empty=1, almost_empty=1, full=0, almost_full=0 (unless AF_LEVEL=0, which is disallowed), rd_valid=0, rd_data=0, overflow=0, underflow=0.
REQ-030 rst SHALL take priority over wr_en, rd_en and clear_err in the same cycle; storage contents need not be cleared.
REQ-031 Reset asserted mid-operation SHALL discard all stored entries; the first read after reset SHALL return the first word written after reset.

Verification (WIDTH=15, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2)
REQ-032 Reset, then write 0x0001..0x0008 on consecutive cycles -> count steps 1..8; almost_empty clears at count 3; almost_full sets at count 6; full=1 after the 8th write; overflow=0.
REQ-033 From full, write 0x7FFF alone -> overflow=1, count=8; subsequent reads return 0x0001..0x0008 in order, each with rd_valid one edge after rd_en; empty=1 after the 8th read.
REQ-034 From empty, rd_en=1 -> underflow=1, rd_valid=0, rd_data unchanged; then clear_err=1 for one cycle -> underflow=0 and overflow=0.
REQ-035 Fill to 8, then hold wr_en=rd_en=1 for 20 cycles with incrementing data -> count stays 8, full stays 1, no overflow, output order is strictly FIFO across pointer wrap.
REQ-036 Write 0x0AAA and 0x0BBB, assert rst, then write 0x0CCC and read -> rd_data=0x0CCC, count=0 after the read.
REQ-037 Empty FIFO with simultaneous wr_en=rd_en=1 and data 0x0123 -> read rejected (underflow=1), write accepted, count=1; next read returns 0x0123.
